// File: rtl/idx_enc.sv
// Sparse spike word to index stream encoder.
// One {last, index} beat per set bit, lowest index first.
module idx_enc #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int ENC_W = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ipt_valid,
  input  logic [WIDTH-1:0] sparse_bits,
  output logic             ipt_ready,
  output logic [ENC_W-1:0] enc,
  output logic             opt_valid,
  input  logic             opt_ready
);

  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] rest;
  logic [IDX_W-1:0] idx;
  logic             busy;
  logic             last;
  logic             found;
  logic             xfer;
  logic             acc;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mask_q[i] && !found) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

  // rest = mask with its lowest set bit removed
  assign rest = mask_q & (mask_q - 1'b1);
  assign busy = (mask_q != '0);
  assign last = busy && (rest == '0);

  // outputs are forced idle while reset is held
  assign opt_valid = busy && !rst_n;
  assign enc       = opt_valid ? {last, idx} : '0;
  assign ipt_ready = !rst_n
                   && (!busy || (opt_ready && last));

  assign xfer = opt_valid && opt_ready;
  assign acc  = ipt_valid && ipt_ready;

  always_comb begin
    mask_d = mask_q;
    if (xfer) mask_d = rest;
    if (acc)  mask_d = sparse_bits;
  end

  always_ff @(posedge clk) begin
    if (rst_n) mask_q <= '0;
    else       mask_q <= mask_d;
  end

endmodule

// File: tb/tb_idx_enc.sv
// Self-checking bench for idx_enc.
// Directed spec scenarios plus a queue-model random run.
module tb_idx_enc;

  logic       clk;
  logic       rst_n;
  logic       ipt_valid;
  logic [7:0] sparse_bits;
  logic       ipt_ready;
  logic [3:0] enc;
  logic       opt_valid;
  logic       opt_ready;

  int checks;
  int errors;

  idx_enc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ipt_valid  (ipt_valid),
    .sparse_bits(sparse_bits),
    .ipt_ready  (ipt_ready),
    .enc        (enc),
    .opt_valid  (opt_valid),
    .opt_ready  (opt_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b1;
    ipt_valid   = 1'b1;
    sparse_bits = 8'hFF;
    opt_ready   = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (opt_valid !== 1'b0 || enc !== 4'h0 || ipt_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got v=%b e=%h r=%b exp 0 0 0",
               opt_valid, enc, ipt_ready);
    end
    tick();
    rst_n     = 1'b0;
    ipt_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (opt_valid !== 1'b0 || ipt_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got v=%b r=%b exp 0 1",
               opt_valid, ipt_ready);
    end
    tick();
  endtask

  task automatic test_a5();
    logic [3:0] exp_e [4];
    exp_e[0] = 4'h0; exp_e[1] = 4'h2;
    exp_e[2] = 4'h5; exp_e[3] = 4'hF;
    opt_ready   = 1'b1;
    ipt_valid   = 1'b1;
    sparse_bits = 8'hA5;
    @(negedge clk);
    checks++;
    if (ipt_ready !== 1'b1) begin
      errors++;
      $display("FAIL a5_accept got r=%b exp 1", ipt_ready);
    end
    tick();
    ipt_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (opt_valid !== 1'b1 || enc !== exp_e[i]) begin
        errors++;
        $display("FAIL a5_beat%0d got v=%b e=%h exp 1 %h",
                 i, opt_valid, enc, exp_e[i]);
      end
      checks++;
      if (ipt_ready !== (i == 3)) begin
        errors++;
        $display("FAIL a5_ready%0d got %b exp %b",
                 i, ipt_ready, (i == 3));
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (opt_valid !== 1'b0 || enc !== 4'h0) begin
      errors++;
      $display("FAIL a5_idle got v=%b e=%h exp 0 0", opt_valid, enc);
    end
  endtask

  task automatic test_single();
    logic [7:0] w [2];
    logic [3:0] e [2];
    w[0] = 8'h80; e[0] = 4'hF;
    w[1] = 8'h01; e[1] = 4'h8;
    opt_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ipt_valid   = 1'b1;
      sparse_bits = w[k];
      tick();
      ipt_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (opt_valid !== 1'b1 || enc !== e[k] || ipt_ready !== 1'b1) begin
        errors++;
        $display("FAIL single_%h got v=%b e=%h r=%b exp 1 %h 1",
                 w[k], opt_valid, enc, ipt_ready, e[k]);
      end
      tick();
      @(negedge clk);
      checks++;
      if (opt_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_%h_done got v=%b exp 0", w[k], opt_valid);
      end
    end
  endtask

  task automatic test_zero();
    ipt_valid   = 1'b1;
    sparse_bits = 8'h00;
    @(negedge clk);
    checks++;
    if (ipt_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_accept got r=%b exp 1", ipt_ready);
    end
    tick();
    ipt_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (opt_valid !== 1'b0 || ipt_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_after got v=%b r=%b exp 0 1",
               opt_valid, ipt_ready);
    end
  endtask

  task automatic test_stall_ff();
    int k;
    int cyc;
    logic [3:0] exp_e;
    k = 0;
    cyc = 0;
    ipt_valid   = 1'b1;
    sparse_bits = 8'hFF;
    opt_ready   = 1'b0;
    tick();
    ipt_valid = 1'b0;
    while (k < 8 && cyc < 200) begin
      opt_ready = ($urandom_range(0, 9) < 8);
      exp_e = (k == 7) ? 4'hF : 4'(k);
      @(negedge clk);
      checks++;
      if (opt_valid !== 1'b1 || enc !== exp_e) begin
        errors++;
        $display("FAIL ff_beat%0d got v=%b e=%h exp 1 %h",
                 k, opt_valid, enc, exp_e);
      end
      if (opt_ready) k++;
      cyc++;
      tick();
    end
    checks++;
    if (k != 8) begin
      errors++;
      $display("FAIL ff_timeout got beats=%0d exp 8", k);
    end
    opt_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (opt_valid !== 1'b0) begin
      errors++;
      $display("FAIL ff_extra got v=%b exp 0", opt_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e [4];
    e[0] = 4'h0; e[1] = 4'h9;
    e[2] = 4'h2; e[3] = 4'hB;
    opt_ready   = 1'b1;
    ipt_valid   = 1'b1;
    sparse_bits = 8'h03;
    tick();
    sparse_bits = 8'h0C;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) ipt_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (opt_valid !== 1'b1 || enc !== e[i]) begin
        errors++;
        $display("FAIL b2b_beat%0d got v=%b e=%h exp 1 %h",
                 i, opt_valid, enc, e[i]);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (opt_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done got v=%b exp 0", opt_valid);
    end
  endtask

  task automatic test_reset_mid();
    opt_ready   = 1'b1;
    ipt_valid   = 1'b1;
    sparse_bits = 8'hF0;
    tick();
    ipt_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (opt_valid !== 1'b1 || enc !== 4'h4) begin
      errors++;
      $display("FAIL mid_first got v=%b e=%h exp 1 4", opt_valid, enc);
    end
    tick();
    rst_n     = 1'b1;
    ipt_valid = 1'b1;
    sparse_bits = 8'h55;
    @(negedge clk);
    checks++;
    if (opt_valid !== 1'b0 || enc !== 4'h0 || ipt_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_in_reset got v=%b e=%h r=%b exp 0 0 0",
               opt_valid, enc, ipt_ready);
    end
    tick();
    rst_n     = 1'b0;
    ipt_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (opt_valid !== 1'b0 || ipt_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_after got v=%b r=%b exp 0 1",
               opt_valid, ipt_ready);
    end
    ipt_valid   = 1'b1;
    sparse_bits = 8'h10;
    tick();
    ipt_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (opt_valid !== 1'b1 || enc !== 4'hC) begin
      errors++;
      $display("FAIL mid_new got v=%b e=%h exp 1 c", opt_valid, enc);
    end
    tick();
    @(negedge clk);
    checks++;
    if (opt_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_resume got v=%b exp 0", opt_valid);
    end
  endtask

  task automatic test_random();
    logic [3:0] q [$];
    logic [3:0] exp_e;
    logic       exp_v;
    logic       exp_r;
    q = {};
    for (int c = 0; c < 400; c++) begin
      ipt_valid   = $urandom_range(0, 1);
      sparse_bits = ($urandom_range(0, 4) == 0) ? 8'h00
                                                : 8'($urandom);
      opt_ready   = ($urandom_range(0, 3) != 0);
      exp_v = (q.size() != 0);
      exp_e = exp_v ? q[0] : 4'h0;
      exp_r = !exp_v || (q.size() == 1 && opt_ready);
      @(negedge clk);
      checks++;
      if (opt_valid !== exp_v || enc !== exp_e || ipt_ready !== exp_r) begin
        errors++;
        $display("FAIL rand_c%0d got v=%b e=%h r=%b exp %b %h %b",
                 c, opt_valid, enc, ipt_ready, exp_v, exp_e, exp_r);
      end
      if (exp_v && opt_ready) void'(q.pop_front());
      if (ipt_valid && exp_r) begin
        q = {};
        for (int i = 0; i < 8; i++)
          if ((sparse_bits >> i) & 8'h1) q.push_back(4'(i));
        if (q.size() != 0) q[q.size()-1] = q[q.size()-1] | 4'h8;
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    ipt_valid = 1'b0;
    sparse_bits = 8'h00;
    opt_ready = 1'b0;
    #1;
    test_reset();
    test_a5();
    tick();
    test_single();
    tick();
    test_zero();
    tick();
    test_stall_ff();
    tick();
    test_back_to_back();
    tick();
    test_reset_mid();
    tick();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
